// File: rtl/reg_file_sb_pkg.sv
// Shared CPU datapath types and register-file sizing for the MIPS pipeline.
// Types only; no logic, no latency, no flow control.
package cpu_types_pkg;
   localparam int NREGS = 32;
   localparam int CNTW  = 2;
   localparam int RSELW = $clog2(NREGS);

   typedef logic [31:0]       word_t;
   typedef logic [RSELW-1:0]  regbits_t;
   typedef logic [CNTW-1:0]   sbcnt_t;

   localparam sbcnt_t CNT_MAX = '1;
endpackage

// File: rtl/reg_file_sb_if.sv
// Decode/write-back to register file bundle: write-back port, read ports, scoreboard.
// master = pipeline side, slave = register file side; no backpressure (stall is advisory).
interface reg_file_sb_if;
   import cpu_types_pkg::*;

   logic              WEN;
   regbits_t          wsel;
   word_t             wdat;
   regbits_t          rsel1;
   regbits_t          rsel2;
   word_t             rdat1;
   word_t             rdat2;
   logic              mark;
   regbits_t          mark_sel;
   logic              ihit;
   logic              flush;
   logic              stall;
   logic [NREGS-1:0]  busy;

   modport master (
      output WEN, wsel, wdat, rsel1, rsel2, mark, mark_sel, ihit, flush,
      input  rdat1, rdat2, stall, busy
   );

   modport slave (
      input  WEN, wsel, wdat, rsel1, rsel2, mark, mark_sel, ihit, flush,
      output rdat1, rdat2, stall, busy
   );
endinterface

// File: rtl/reg_file_sb_counter.sv
// Saturating pending-writer counter for one register; flush clears, same-cycle inc+dec cancel.
// One-cycle update latency; decrement at zero is ignored.
module reg_sb_counter
   import cpu_types_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   inc,
   input  logic   dec,
   input  logic   flush,
   output sbcnt_t cnt
);
   logic dec_ok;

   assign dec_ok = dec && (cnt != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (flush) begin
         cnt <= '0;
      end else if (inc && !dec_ok) begin
         if (cnt != CNT_MAX) cnt <= cnt + sbcnt_t'(1);
      end else if (dec_ok && !inc) begin
         cnt <= cnt - sbcnt_t'(1);
      end
   end
endmodule

// File: rtl/reg_file_sb.sv
// 32x32 GPR file with combinational reads and per-register RAW scoreboard; writes visible next cycle.
// REGFILE_BYPASS_EN adds write-through reads and retire-aware stall; stall is advisory, never backpressures write-back.
module reg_file_sb
   import cpu_types_pkg::*;
(
   input  logic          CLK,
   input  logic          nRST,
   reg_file_sb_if.slave  rf
);
   word_t                       regs [NREGS];
   logic [NREGS-1:0][CNTW-1:0]  cnt;
   logic [NREGS-1:0]            busy_v;
   logic [NREGS-1:0]            hold_v;

   // reg 0 is reset and never written, so it reduces to a constant zero
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (rf.WEN && (rf.wsel != '0)) begin
         regs[rf.wsel] <= rf.wdat;
      end
   end

   assign cnt[0] = '0;

   generate
      for (genvar r = 1; r < NREGS; r++) begin : g_cnt
         logic inc;
         logic dec;
         assign inc = rf.ihit && rf.mark && (rf.mark_sel == regbits_t'(r));
         assign dec = rf.WEN && (rf.wsel == regbits_t'(r));
         reg_sb_counter u_cnt (
            .clk   (CLK),
            .rst_n (nRST),
            .inc   (inc),
            .dec   (dec),
            .flush (rf.flush),
            .cnt   (cnt[r])
         );
      end
   endgenerate

   always_comb begin
      busy_v = '0;
      hold_v = '0;
      for (int r = 1; r < NREGS; r++) begin
         busy_v[r] = (cnt[r] != '0);
`ifdef REGFILE_BYPASS_EN
         // a last writer retiring now is already satisfied via the bypass
         hold_v[r] = busy_v[r] && !((cnt[r] == sbcnt_t'(1)) && rf.WEN &&
                                    (rf.wsel == regbits_t'(r)));
`else
         hold_v[r] = busy_v[r];
`endif
      end
   end

   always_comb begin
      rf.rdat1 = regs[rf.rsel1];
      rf.rdat2 = regs[rf.rsel2];
`ifdef REGFILE_BYPASS_EN
      if (rf.WEN && (rf.wsel != '0) && (rf.wsel == rf.rsel1)) rf.rdat1 = rf.wdat;
      if (rf.WEN && (rf.wsel != '0) && (rf.wsel == rf.rsel2)) rf.rdat2 = rf.wdat;
`endif
   end

   assign rf.busy  = busy_v;
   assign rf.stall = hold_v[rf.rsel1] | hold_v[rf.rsel2];
endmodule

// File: tb/tb_reg_file_sb.sv
// Randomized bench for reg_file_sb against an array/arithmetic reference model, plus directed corner cases.
module tb_reg_file_sb;
   logic CLK = 1'b0;
   logic nRST = 1'b0;
   int   n_checks = 0;
   int   n_err = 0;
   int   n_proto = 0;

   logic [31:0] m_regs [32];
   int          m_cnt  [32];

   reg_file_sb_if rf ();

   reg_file_sb dut (
      .CLK  (CLK),
      .nRST (nRST),
      .rf   (rf)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic idle();
      rf.WEN = 0; rf.wsel = 0; rf.wdat = 0;
      rf.mark = 0; rf.mark_sel = 0; rf.ihit = 0; rf.flush = 0;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         m_regs[i] = 0;
         m_cnt[i]  = 0;
      end
   endtask

   function automatic logic [31:0] exp_rd(input logic [4:0] s);
      if (s == 0) return 0;
`ifdef REGFILE_BYPASS_EN
      if (rf.WEN && rf.wsel == s) return rf.wdat;
`endif
      return m_regs[s];
   endfunction

   function automatic logic pend(input logic [4:0] s);
      if (s == 0 || m_cnt[s] == 0) return 0;
`ifdef REGFILE_BYPASS_EN
      if (m_cnt[s] == 1 && rf.WEN && rf.wsel == s) return 0;
`endif
      return 1;
   endfunction

   function automatic logic [31:0] exp_busy();
      logic [31:0] b = 0;
      for (int i = 1; i < 32; i++) b[i] = (m_cnt[i] != 0);
      return b;
   endfunction

   task automatic check_outputs(input string tag);
      chk({tag, ".rdat1"}, rf.rdat1, exp_rd(rf.rsel1));
      chk({tag, ".rdat2"}, rf.rdat2, exp_rd(rf.rsel2));
      chk({tag, ".stall"}, {31'b0, rf.stall}, {31'b0, pend(rf.rsel1) | pend(rf.rsel2)});
      chk({tag, ".busy"}, rf.busy, exp_busy());
   endtask

   // Applies the architectural rules for one clock edge using the inputs held across it.
   task automatic model_edge();
      int inc, dec, nxt;
      if (rf.WEN && rf.wsel != 0) m_regs[rf.wsel] = rf.wdat;
      for (int r = 1; r < 32; r++) begin
         inc = (rf.ihit && rf.mark && rf.mark_sel == r) ? 1 : 0;
         dec = (rf.WEN && rf.wsel == r && m_cnt[r] > 0) ? 1 : 0;
         if (rf.WEN && rf.wsel == r && m_cnt[r] == 0) n_proto++;
         nxt = m_cnt[r] + inc - dec;
         m_cnt[r] = rf.flush ? 0 : (nxt > 3 ? 3 : nxt);
      end
   endtask

   task automatic cycle();
      @(posedge CLK);
      model_edge();
      #1;
   endtask

   task automatic mark_reg(input logic [4:0] r);
      idle();
      rf.ihit = 1; rf.mark = 1; rf.mark_sel = r;
      cycle();
      idle();
   endtask

   task automatic wb(input logic [4:0] r, input logic [31:0] d);
      idle();
      rf.WEN = 1; rf.wsel = r; rf.wdat = d;
      cycle();
      idle();
   endtask

   task automatic rand_cycle();
      int q[$];
      rf.rsel1    = 5'($urandom_range(0, 31));
      rf.rsel2    = 5'($urandom_range(0, 31));
      rf.ihit     = ($urandom_range(0, 3) != 0);
      rf.mark     = $urandom_range(0, 1);
      rf.mark_sel = 5'($urandom_range(0, 31));
      rf.flush    = ($urandom_range(0, 49) == 0);
      rf.wdat     = $urandom;
      rf.WEN      = 0;
      rf.wsel     = 0;
      for (int i = 1; i < 32; i++) if (m_cnt[i] > 0) q.push_back(i);
      if (q.size() > 0 && $urandom_range(0, 9) < 6) begin
         rf.WEN  = 1;
         rf.wsel = 5'(q[$urandom_range(0, q.size() - 1)]);
      end else if ($urandom_range(0, 19) == 0) begin
         rf.WEN  = 1;
         rf.wsel = 0;
      end
      #1;
      check_outputs("rand");
      cycle();
   endtask

   initial begin
      idle();
      rf.rsel1 = 0; rf.rsel2 = 0;
      model_reset();
      #12;
      chk("rst.busy", rf.busy, 32'h0);
      chk("rst.stall", {31'b0, rf.stall}, 32'h0);
      nRST = 1;
      @(posedge CLK); #1;

      // write then read, and reg 0 ignores writes
      wb(5'd5, 32'hDEADBEEF);
      rf.rsel1 = 5; #1;
      chk("wr5.rdat1", rf.rdat1, 32'hDEADBEEF);
      wb(5'd0, 32'hFFFFFFFF);
      rf.rsel2 = 0; #1;
      chk("wr0.rdat2", rf.rdat2, 32'h0);

      // two pending writers on reg 8
      mark_reg(5'd8);
      mark_reg(5'd8);
      rf.rsel1 = 8; rf.rsel2 = 0; #1;
      chk("m8.busy8", {31'b0, rf.busy[8]}, 32'h1);
      chk("m8.stall", {31'b0, rf.stall}, 32'h1);
      wb(5'd8, 32'h8);
      chk("m8.wb1.stall", {31'b0, rf.stall}, 32'h1);
      wb(5'd8, 32'h88);
      chk("m8.wb2.stall", {31'b0, rf.stall}, 32'h0);
      check_outputs("m8");

      // same-cycle issue and retire on reg 3 cancel
      mark_reg(5'd3);
      rf.ihit = 1; rf.mark = 1; rf.mark_sel = 3;
      rf.WEN = 1; rf.wsel = 3; rf.wdat = 32'h33;
      cycle();
      idle();
      chk("m3.busy3", {31'b0, rf.busy[3]}, 32'h1);
      wb(5'd3, 32'h333);
      chk("m3.clr", {31'b0, rf.busy[3]}, 32'h0);

      // saturation at 3 on reg 9: third retire must clear it
      for (int i = 0; i < 4; i++) mark_reg(5'd9);
      wb(5'd9, 32'h1);
      wb(5'd9, 32'h2);
      chk("sat9.busy_after2", {31'b0, rf.busy[9]}, 32'h1);
      wb(5'd9, 32'h3);
      chk("sat9.busy_after3", {31'b0, rf.busy[9]}, 32'h0);

      // flush clears all counters but the write still lands
      mark_reg(5'd9);
      mark_reg(5'd10);
      idle();
      rf.flush = 1; rf.WEN = 1; rf.wsel = 9; rf.wdat = 32'h12;
      cycle();
      idle();
      rf.rsel1 = 9; #1;
      chk("flush.busy", rf.busy, 32'h0);
      chk("flush.rdat9", rf.rdat1, 32'h12);

      // retire-cycle visibility on reg 4
      mark_reg(5'd4);
      rf.rsel1 = 4; rf.rsel2 = 0;
      rf.WEN = 1; rf.wsel = 4; rf.wdat = 32'h55;
      #1;
`ifdef REGFILE_BYPASS_EN
      chk("byp.rdat1", rf.rdat1, 32'h55);
      chk("byp.stall", {31'b0, rf.stall}, 32'h0);
`else
      chk("byp.rdat1", rf.rdat1, 32'h0);
      chk("byp.stall", {31'b0, rf.stall}, 32'h1);
`endif
      cycle();
      idle();
      check_outputs("byp.after");

      for (int n = 0; n < 2000; n++) rand_cycle();

      // asynchronous reset mid-cycle with live state
      idle();
      #3;
      nRST = 0;
      model_reset();
      #1;
      for (int i = 0; i < 32; i++) begin
         rf.rsel1 = 5'(i);
         rf.rsel2 = 5'(31 - i);
         #1;
         chk("arst.rdat1", rf.rdat1, 32'h0);
         chk("arst.rdat2", rf.rdat2, 32'h0);
         chk("arst.stall", {31'b0, rf.stall}, 32'h0);
      end
      chk("arst.busy", rf.busy, 32'h0);
      @(negedge CLK);
      nRST = 1;
      @(posedge CLK); #1;
      for (int n = 0; n < 300; n++) rand_cycle();

      $display("note: %0d write-backs hit registers with no pending writer", n_proto);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end
endmodule
